// File: rtl/pac_loop_unit_pkg.sv
// Shared types for the scalar-unit program address controller.
//   address_t  : program address (default 16-bit configuration)
//   issue_no_t : issue stamp, compared modulo its width
//   state_t    : status register, cond_t indexes one bit of it
//   pac_fsm_t  : controller state
//   pac_loop_t : loop-stack entry in the default configuration
//   issue_next : issue stamp + 1, wrapping
package pkg_tpu;

    typedef logic [15:0] address_t;
    typedef logic [3:0]  issue_no_t;
    typedef logic [7:0]  state_t;
    typedef logic [2:0]  cond_t;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_COND = 2'd1,
        FAULT     = 2'd2
    } pac_fsm_t;

    typedef struct packed {
        address_t    start_addr;
        address_t    end_addr;
        logic [15:0] cnt;
    } pac_loop_t;

    function automatic issue_no_t issue_next(input issue_no_t n);
        return n + issue_no_t'(1);
    endfunction

endpackage

// File: rtl/pac_loop_unit_lifo.sv
// pac_lifo: small parametrised stack used for the return-address stack and
// the loop stack.
//   clock, reset : clock and synchronous active-high reset (empties stack)
//   push_i       : push din_i (ignored when full)
//   pop_i        : drop top entry (ignored when empty)
//   wr_top_i     : overwrite top entry with din_i (lowest priority)
//   din_i        : data for push / top overwrite
//   top_o        : current top entry (undefined when empty)
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
module pac_lifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             wr_top_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] top_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    top_idx;

    assign wr_idx  = IW'(count_q);
    assign top_idx = IW'(count_q - CW'(1));
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign top_o   = mem_q[top_idx];

    // Entry storage needs no reset: only entries below count_q are ever read.
    always_ff @(posedge clock) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= din_i;
        end else if (wr_top_i && !pop_i && !empty_o) begin
            mem_q[top_idx] <= din_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (push_i && !full_o) begin
            count_q <= count_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/pac_loop_unit.sv
// pac_loop_unit: program address controller. Holds the PC and issues fetch
// requests; resolves jumps, timing-qualified conditional branches,
// call/return through a return-address stack and zero-overhead loops through
// a loop stack.
//   clock, reset        : clock, synchronous active-high reset
//   I_Req, I_Stall      : fetch request, gated by forced stall
//   I_Sel_CondValid     : selects one of the I_CondValid channels
//   I_CondValid         : condition-valid pulses
//   I_Jump..I_LoopSet   : control-op decode
//   I_Timing_MY/_WB     : issue stamps of this op and of the evaluating op
//   I_State, I_Cond     : status register and bit index for branches
//   I_Src               : jump/call target, branch offset or loop end
//   I_LoopCnt           : loop iteration count
//   O_IFetch            : registered fetch request
//   O_Address           : registered program counter
//   O_StallReq          : high while waiting for a condition or faulted
//   O_Fault             : sticky stack overflow/underflow
module pac_loop_unit
    import pkg_tpu::*;
#(
    parameter int WIDTH_ADDR = 16,
    parameter int WIDTH_LCNT = 16,
    parameter int DEPTH_RAS  = 4,
    parameter int DEPTH_LOOP = 2,
    parameter int NUM_COND   = 2
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          I_Req,
    input  logic                                          I_Stall,
    input  logic [((NUM_COND > 1) ? $clog2(NUM_COND) : 1)-1:0] I_Sel_CondValid,
    input  logic [NUM_COND-1:0]                           I_CondValid,
    input  logic                                          I_Jump,
    input  logic                                          I_Branch,
    input  logic                                          I_Call,
    input  logic                                          I_Return,
    input  logic                                          I_LoopSet,
    input  issue_no_t                                     I_Timing_MY,
    input  issue_no_t                                     I_Timing_WB,
    input  state_t                                        I_State,
    input  cond_t                                         I_Cond,
    input  logic [WIDTH_ADDR-1:0]                         I_Src,
    input  logic [WIDTH_LCNT-1:0]                         I_LoopCnt,
    output logic                                          O_IFetch,
    output logic [WIDTH_ADDR-1:0]                         O_Address,
    output logic                                          O_StallReq,
    output logic                                          O_Fault
);

    localparam int LOOP_W = 2 * WIDTH_ADDR + WIDTH_LCNT;

    typedef struct packed {
        logic [WIDTH_ADDR-1:0] start_addr;
        logic [WIDTH_ADDR-1:0] end_addr;
        logic [WIDTH_LCNT-1:0] cnt;
    } loop_ent_t;

    pac_fsm_t              fsm_q, fsm_d;
    logic [WIDTH_ADDR-1:0] pc_q, pc_d, pc_inc;
    logic [WIDTH_ADDR-1:0] br_off_q, br_off_d;
    cond_t                 br_cond_q, br_cond_d;
    logic                  cv_q, cv_d;
    logic                  ifetch_q;
    logic                  req, cond_sel, br_eligible;

    logic                  ras_push, ras_pop, ras_full, ras_empty;
    logic [WIDTH_ADDR-1:0] ras_top;

    logic                  loop_push, loop_pop, loop_wr, loop_full, loop_empty;
    loop_ent_t             loop_din, loop_top;
    logic [LOOP_W-1:0]     loop_top_raw;

    // Sequential-advance candidate (with loop-end check on the top entry only)
    logic [WIDTH_ADDR-1:0] seq_pc;
    logic                  seq_pop, seq_wr;
    loop_ent_t             seq_ent;

    assign req         = I_Req & ~I_Stall;
    assign cond_sel    = I_CondValid[I_Sel_CondValid];
    assign br_eligible = (I_Timing_MY == issue_next(I_Timing_WB));
    assign pc_inc      = pc_q + WIDTH_ADDR'(1);
    assign loop_top    = loop_top_raw;

    assign O_Address  = pc_q;
    assign O_IFetch   = ifetch_q & (fsm_q != FAULT);
    assign O_StallReq = (fsm_q != RUN);
    assign O_Fault    = (fsm_q == FAULT);

    pac_lifo #(.WIDTH(WIDTH_ADDR), .DEPTH(DEPTH_RAS)) u_ras (
        .clock    (clock),
        .reset    (reset),
        .push_i   (ras_push),
        .pop_i    (ras_pop),
        .wr_top_i (1'b0),
        .din_i    (pc_inc),
        .top_o    (ras_top),
        .full_o   (ras_full),
        .empty_o  (ras_empty)
    );

    pac_lifo #(.WIDTH(LOOP_W), .DEPTH(DEPTH_LOOP)) u_loop (
        .clock    (clock),
        .reset    (reset),
        .push_i   (loop_push),
        .pop_i    (loop_pop),
        .wr_top_i (loop_wr),
        .din_i    (loop_din),
        .top_o    (loop_top_raw),
        .full_o   (loop_full),
        .empty_o  (loop_empty)
    );

    always_comb begin
        seq_pc  = pc_inc;
        seq_pop = 1'b0;
        seq_wr  = 1'b0;
        seq_ent = loop_top;
        if (!loop_empty && (pc_q == loop_top.end_addr)) begin
            if (loop_top.cnt > WIDTH_LCNT'(1)) begin
                seq_pc      = loop_top.start_addr;
                seq_wr      = 1'b1;
                seq_ent.cnt = loop_top.cnt - WIDTH_LCNT'(1);
            end else begin
                // Last iteration: fall through past the loop end.
                seq_pop = 1'b1;
            end
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        pc_d      = pc_q;
        cv_d      = cv_q | cond_sel;
        br_off_d  = br_off_q;
        br_cond_d = br_cond_q;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        loop_push = 1'b0;
        loop_pop  = 1'b0;
        loop_wr   = 1'b0;
        loop_din  = seq_ent;

        unique case (fsm_q)
            RUN: begin
                if (req) begin
                    if (I_Return) begin
                        if (ras_empty) begin
                            fsm_d = FAULT;
                        end else begin
                            ras_pop = 1'b1;
                            pc_d    = ras_top;
                        end
                    end else if (I_Call) begin
                        if (ras_full) begin
                            fsm_d = FAULT;
                        end else begin
                            ras_push = 1'b1;
                            pc_d     = I_Src;
                        end
                    end else if (I_Jump) begin
                        pc_d = I_Src;
                    end else if (I_LoopSet) begin
                        if (I_LoopCnt == '0) begin
                            pc_d = I_Src + WIDTH_ADDR'(1);
                        end else if (loop_full) begin
                            fsm_d = FAULT;
                        end else begin
                            loop_push           = 1'b1;
                            loop_din.start_addr = pc_inc;
                            loop_din.end_addr   = I_Src;
                            loop_din.cnt        = I_LoopCnt;
                            pc_d                = pc_inc;
                        end
                    end else if (I_Branch && br_eligible) begin
                        if (cv_q || cond_sel) begin
                            cv_d = 1'b0;
                            if (I_State[I_Cond]) begin
                                pc_d = pc_q + I_Src;
                            end else begin
                                pc_d     = seq_pc;
                                loop_pop = seq_pop;
                                loop_wr  = seq_wr;
                            end
                        end else begin
                            // Condition not yet produced: park the operands.
                            fsm_d     = WAIT_COND;
                            br_off_d  = I_Src;
                            br_cond_d = I_Cond;
                        end
                    end else begin
                        pc_d     = seq_pc;
                        loop_pop = seq_pop;
                        loop_wr  = seq_wr;
                    end
                end
            end
            WAIT_COND: begin
                if (cond_sel) begin
                    cv_d  = 1'b0;
                    fsm_d = RUN;
                    if (I_State[br_cond_q]) begin
                        pc_d = pc_q + br_off_q;
                    end else begin
                        pc_d     = seq_pc;
                        loop_pop = seq_pop;
                        loop_wr  = seq_wr;
                    end
                end
            end
            FAULT: begin
                fsm_d = FAULT;
            end
            default: begin
                fsm_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q     <= RUN;
            pc_q      <= '0;
            cv_q      <= 1'b0;
            ifetch_q  <= 1'b0;
            br_off_q  <= '0;
            br_cond_q <= '0;
        end else begin
            fsm_q     <= fsm_d;
            pc_q      <= pc_d;
            cv_q      <= cv_d;
            ifetch_q  <= req;
            br_off_q  <= br_off_d;
            br_cond_q <= br_cond_d;
        end
    end

endmodule
